// File: rtl/adxl345_pkg.sv
// Shared constants and state encodings for the ADXL345 sequencer.
// Register map, expected DEVID and burst length.
package adxl345_pkg;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    localparam logic [7:0] DEVID_VAL = 8'hE5;
    localparam int unsigned BURST_LEN = 6;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_ID,
        ST_CFG,
        ST_IDLE,
        ST_RD,
        ST_PUBLISH,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        HS_REQ,
        HS_WAIT_LO,
        HS_WAIT_HI
    } hs_e;

endpackage

// File: rtl/ctrl_xfer_handshake.sv
// One SPI transaction: start pulse, busy-then-ready tracking, timeout.
// Shared by the DEVID read, config writes and the burst read.
module ctrl_xfer_handshake #(
    parameter int unsigned TIMEOUT_CLKS = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic spi_ready_i,
    output logic start_o,
    output logic busy_o,
    output logic done_o,
    output logic timeout_o
);
    import adxl345_pkg::*;

    hs_e         ph_q, ph_d;
    logic [31:0] tmo_q, tmo_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q  <= HS_REQ;
            tmo_q <= '0;
        end else begin
            ph_q  <= ph_d;
            tmo_q <= tmo_d;
        end
    end

    always_comb begin
        ph_d  = ph_q;
        tmo_d = tmo_q;
        unique case (ph_q)
            HS_REQ: begin
                if (req_i && spi_ready_i) begin
                    ph_d  = HS_WAIT_LO;
                    tmo_d = 32'd1;
                end
            end
            HS_WAIT_LO: if (!spi_ready_i) ph_d = HS_WAIT_HI;
            HS_WAIT_HI: if (spi_ready_i) ph_d = HS_REQ;
            default:    ph_d = HS_REQ;
        endcase
        // tmo_q counts clocks since the start pulse
        if (ph_q != HS_REQ) begin
            if (tmo_q >= TIMEOUT_CLKS) ph_d = HS_REQ;
            else tmo_d = tmo_q + 32'd1;
        end
    end

    always_comb begin
        start_o   = (ph_q == HS_REQ) && req_i && spi_ready_i;
        busy_o    = (ph_q != HS_REQ);
        timeout_o = busy_o && (tmo_q >= TIMEOUT_CLKS);
        done_o    = (ph_q == HS_WAIT_HI) && spi_ready_i && !timeout_o;
    end

endmodule

// File: rtl/adxl345_ctrl.sv
// ADXL345 sequencer: DEVID check, config writes, periodic XYZ burst read.
// Publishes signed 16-bit samples with a one-cycle valid pulse.
module adxl345_ctrl #(
    parameter int unsigned SAMPLE_PERIOD_CLKS = 120000,
    parameter int unsigned PWRUP_DELAY_CLKS   = 24000,
    parameter int unsigned RETRY_DELAY_CLKS   = 120000,
    parameter int unsigned TIMEOUT_CLKS       = 4096,
    parameter logic [7:0]  BW_RATE_VAL        = 8'h0A,
    parameter logic [7:0]  DATA_FORMAT_VAL    = 8'h08,
    parameter logic [7:0]  POWER_CTL_VAL      = 8'h08
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    output logic        o_spi_start,
    output logic        o_spi_rw_n,
    output logic        o_spi_multibyte_rd,
    output logic [5:0]  o_spi_addr,
    output logic [7:0]  o_spi_datain,
    input  logic        i_spi_ready,
    input  logic        i_spi_dataval,
    input  logic [7:0]  i_spi_dataout,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic [15:0] o_z,
    output logic        o_sample_valid,
    output logic        o_init_done,
    output logic        o_id_error,
    output logic        o_xfer_error
);
    import adxl345_pkg::*;

    localparam logic [2:0] BurstIdx  = 3'(BURST_LEN);
    localparam logic [7:0] BurstByte = 8'(BURST_LEN);

    state_e         state_q, state_d;
    logic [31:0]    dly_q, dly_d;
    logic [31:0]    per_q;
    logic [1:0]     cfg_q;
    logic [7:0]     id_q;
    logic [2:0]     idx_q;
    logic [5:0][7:0] buf_q;
    logic [15:0]    x_q, y_q, z_q;
    logic           valid_q, init_q, iderr_q, xerr_q;

    logic           hs_req, hs_start, hs_busy, hs_done, hs_tmo;
    logic           cfg_last;

    ctrl_xfer_handshake #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_hs (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .req_i      (hs_req),
        .spi_ready_i(i_spi_ready),
        .start_o    (hs_start),
        .busy_o     (hs_busy),
        .done_o     (hs_done),
        .timeout_o  (hs_tmo)
    );

    assign cfg_last = (state_q == ST_CFG) && hs_done && (cfg_q == 2'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_PWRUP;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PWRUP: if (dly_q >= PWRUP_DELAY_CLKS - 1) state_d = ST_ID;
            ST_ID: begin
                if (hs_tmo) state_d = ST_ERR;
                else if (hs_done)
                    state_d = (id_q == DEVID_VAL) ? ST_CFG : ST_ERR;
            end
            ST_CFG: begin
                if (hs_tmo) state_d = ST_ERR;
                else if (cfg_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_enable && per_q >= SAMPLE_PERIOD_CLKS - 1)
                    state_d = ST_RD;
            end
            ST_RD: begin
                if (hs_tmo) state_d = ST_ERR;
                else if (hs_done) state_d = ST_PUBLISH;
            end
            ST_PUBLISH: state_d = ST_IDLE;
            ST_ERR: if (dly_q >= RETRY_DELAY_CLKS - 1) state_d = ST_ID;
            default: state_d = ST_PWRUP;
        endcase
        dly_d = '0;
        if ((state_q == ST_PWRUP || state_q == ST_ERR) && state_d == state_q)
            dly_d = dly_q + 32'd1;
    end

    always_comb begin
        hs_req             = 1'b0;
        o_spi_rw_n         = 1'b0;
        o_spi_multibyte_rd = 1'b0;
        o_spi_addr         = '0;
        o_spi_datain       = '0;
        unique case (state_q)
            ST_ID: begin
                hs_req     = 1'b1;
                o_spi_rw_n = 1'b1;
                o_spi_addr = REG_DEVID;
            end
            ST_CFG: begin
                hs_req = 1'b1;
                unique case (cfg_q)
                    2'd0: begin
                        o_spi_addr   = REG_BW_RATE;
                        o_spi_datain = BW_RATE_VAL;
                    end
                    2'd1: begin
                        o_spi_addr   = REG_DATA_FORMAT;
                        o_spi_datain = DATA_FORMAT_VAL;
                    end
                    default: begin
                        o_spi_addr   = REG_POWER_CTL;
                        o_spi_datain = POWER_CTL_VAL;
                    end
                endcase
            end
            ST_RD: begin
                hs_req             = 1'b1;
                o_spi_rw_n         = 1'b1;
                o_spi_multibyte_rd = 1'b1;
                o_spi_addr         = REG_DATAX0;
                o_spi_datain       = BurstByte;
            end
            default: hs_req = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_q   <= '0;
            id_q    <= '0;
            iderr_q <= 1'b0;
            init_q  <= 1'b0;
            per_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            xerr_q  <= 1'b0;
        end else begin
            if (state_q == ST_ID) cfg_q <= '0;
            else if (state_q == ST_CFG && hs_done) cfg_q <= cfg_q + 2'd1;

            if (state_q == ST_ID && hs_busy && i_spi_dataval)
                id_q <= i_spi_dataout;
            if (state_q == ST_ID && hs_done)
                iderr_q <= (id_q != DEVID_VAL);

            if (cfg_last) init_q <= 1'b1;
            else if (state_q == ST_ERR) init_q <= 1'b0;

            // Saturated after config so the first read launches at once
            if (state_q == ST_RD && hs_start) per_q <= 32'd1;
            else if (cfg_last) per_q <= SAMPLE_PERIOD_CLKS;
            else if (per_q < SAMPLE_PERIOD_CLKS) per_q <= per_q + 32'd1;

            if (state_q == ST_RD && hs_start) begin
                idx_q <= '0;
            end else if (state_q == ST_RD && hs_busy && i_spi_dataval
                         && idx_q < BurstIdx) begin
                buf_q[idx_q] <= i_spi_dataout;
                idx_q        <= idx_q + 3'd1;
            end

            valid_q <= 1'b0;
            xerr_q  <= hs_tmo;
            if (state_q == ST_PUBLISH) begin
                if (idx_q == BurstIdx) begin
                    x_q     <= {buf_q[1], buf_q[0]};
                    y_q     <= {buf_q[3], buf_q[2]};
                    z_q     <= {buf_q[5], buf_q[4]};
                    valid_q <= 1'b1;
                end else begin
                    xerr_q  <= 1'b1;
                end
            end
        end
    end

    assign o_spi_start    = hs_start;
    assign o_x            = x_q;
    assign o_y            = y_q;
    assign o_z            = z_q;
    assign o_sample_valid = valid_q;
    assign o_init_done    = init_q;
    assign o_id_error     = iderr_q;
    assign o_xfer_error   = xerr_q;

endmodule

// File: tb/tb_adxl345_ctrl.sv
// Directed bench for adxl345_ctrl with a behavioural spi_module model.
// Short timing parameters keep the run small.
module tb_adxl345_ctrl;

    localparam int P  = 300;
    localparam int PW = 20;
    localparam int RT = 100;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        spi_ready = 1'b1;
    logic        spi_dv = 1'b0;
    logic [7:0]  spi_do = 8'h00;
    logic        spi_start, spi_rw_n, spi_mb;
    logic [5:0]  spi_addr;
    logic [7:0]  spi_din;
    logic [15:0] ox, oy, oz;
    logic        sval, initd, iderr, xerr;

    typedef struct {
        logic [5:0] a;
        logic       rw;
        logic       mb;
        logic [7:0] d;
        int         c;
    } xact_t;

    xact_t      log_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         sv_cnt = 0;
    int         xe_cnt = 0;
    int         xe_cyc = 0;
    int         viol = 0;
    logic [7:0] devid = 8'hE5;
    int         burst_n = 6;
    logic [7:0] burst [8];
    bit         stall = 1'b0;

    adxl345_ctrl #(
        .SAMPLE_PERIOD_CLKS(P),
        .PWRUP_DELAY_CLKS  (PW),
        .RETRY_DELAY_CLKS  (RT),
        .TIMEOUT_CLKS      (TO)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_enable          (en),
        .o_spi_start       (spi_start),
        .o_spi_rw_n        (spi_rw_n),
        .o_spi_multibyte_rd(spi_mb),
        .o_spi_addr        (spi_addr),
        .o_spi_datain      (spi_din),
        .i_spi_ready       (spi_ready),
        .i_spi_dataval     (spi_dv),
        .i_spi_dataout     (spi_do),
        .o_x               (ox),
        .o_y               (oy),
        .o_z               (oz),
        .o_sample_valid    (sval),
        .o_init_done       (initd),
        .o_id_error        (iderr),
        .o_xfer_error      (xerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (sval) sv_cnt <= sv_cnt + 1;
            if (xerr) begin
                xe_cnt <= xe_cnt + 1;
                xe_cyc <= cyc;
            end
            if (spi_start && !spi_ready) viol <= viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] a, input logic rw,
                                       input logic mb, input logic [7:0] d);
        return {16'h0, a, rw, mb, d};
    endfunction

    function automatic logic [31:0] xw(input int i);
        if (i >= log_q.size()) return 32'hFFFF_FFFF;
        return mk(log_q[i].a, log_q[i].rw, log_q[i].mb, log_q[i].d);
    endfunction

    function automatic logic [31:0] gap(input int i, input int j);
        if (i >= log_q.size() || j >= log_q.size()) return 32'hFFFF_FFFF;
        return 32'(log_q[j].c - log_q[i].c);
    endfunction

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_q.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_sv(input int n, input string tag);
        int k = 0;
        while (sv_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(sv_cnt >= n), 32'd1);
    endtask

    task automatic wait_xe(input int n, input string tag);
        int k = 0;
        while (xe_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(xe_cnt >= n), 32'd1);
    endtask

    task automatic set_burst(input logic [63:0] v, input int n);
        for (int i = 0; i < 8; i++) burst[i] = v[63-8*i -: 8];
        burst_n = n;
    endtask

    // spi_module + register file model, driven on falling edges
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                log_q.push_back('{a: spi_addr, rw: spi_rw_n, mb: spi_mb,
                                  d: spi_din, c: cyc});
                n = !spi_rw_n ? 0 : (spi_mb ? burst_n : 1);
                @(negedge clk);
                spi_ready = 1'b0;
                @(negedge clk);
                if (stall) begin
                    while (stall) @(negedge clk);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        spi_do = spi_mb ? burst[i] : devid;
                        spi_dv = 1'b1;
                        @(negedge clk);
                        spi_dv = 1'b0;
                        @(negedge clk);
                    end
                end
                spi_ready = 1'b1;
            end
        end
    end

    initial begin
        int e;
        set_burst(64'h3412_CDAB_0100_0000, 6);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(spi_start), 32'd0);
        chk("rst_rw", 32'(spi_rw_n), 32'd0);
        chk("rst_init", 32'(initd), 32'd0);
        chk("rst_iderr", 32'(iderr), 32'd0);
        chk("rst_valid", 32'(sval), 32'd0);
        chk("rst_xerr", 32'(xerr), 32'd0);
        chk("rst_xyz", {ox, oy | oz}, 32'd0);

        rst_n = 1'b1;
        en = 1'b1;
        repeat (150) @(negedge clk);
        chk("init_nx", 32'(log_q.size()), 32'd5);
        chk("id_rd", xw(0), mk(6'h00, 1'b1, 1'b0, 8'h00));
        chk("cfg_bw", xw(1), mk(6'h2C, 1'b0, 1'b0, 8'h0A));
        chk("cfg_df", xw(2), mk(6'h31, 1'b0, 1'b0, 8'h08));
        chk("cfg_pc", xw(3), mk(6'h2D, 1'b0, 1'b0, 8'h08));
        chk("rd1", xw(4), mk(6'h32, 1'b1, 1'b1, 8'd6));
        chk("init_done", 32'(initd), 32'd1);
        chk("iderr_lo", 32'(iderr), 32'd0);
        chk("sv_one", 32'(sv_cnt), 32'd1);
        chk("x1", 32'(ox), 32'h1234);
        chk("y1", 32'(oy), 32'hABCD);
        chk("z1", 32'(oz), 32'h0001);
        chk("xe_none", 32'(xe_cnt), 32'd0);

        wait_log(6, "w_rd2");
        chk("period1", gap(4, 5), 32'(P));
        wait_sv(2, "w_sv2");
        set_burst(64'h7856_EFCD_2301_9999, 8);
        wait_sv(3, "w_sv3");
        chk("x_long", 32'(ox), 32'h5678);
        chk("y_long", 32'(oy), 32'hCDEF);
        chk("z_long", 32'(oz), 32'h0123);

        wait_log(8, "w_rd4");
        repeat (3) @(negedge clk);
        en = 1'b0;
        wait_sv(4, "w_sv_park");
        repeat (700) @(negedge clk);
        chk("parked", 32'(log_q.size()), 32'd8);
        chk("parked_sv", 32'(sv_cnt), 32'd4);
        en = 1'b1;
        e = cyc;
        wait_log(9, "w_resume");
        chk("resume_lat", (log_q.size() > 8) ? 32'(log_q[8].c - e) : 32'hFFFF,
            32'd1);
        wait_log(10, "w_rd_after");
        chk("period2", gap(8, 9), 32'(P));

        wait_sv(6, "w_sv6");
        set_burst(64'h1122_3344_0000_0000, 4);
        wait_xe(1, "w_short");
        repeat (3) @(negedge clk);
        chk("short_sv", 32'(sv_cnt), 32'd6);
        chk("short_x", 32'(ox), 32'h5678);
        chk("short_yz", {oy, oz}, 32'hCDEF_0123);

        set_burst(64'h3412_CDAB_0100_0000, 6);
        stall = 1'b1;
        wait_log(12, "w_stall_rd");
        wait_xe(2, "w_tmo");
        chk("tmo_lat", (log_q.size() > 11) ? 32'(xe_cyc - log_q[11].c) : 32'hFFFF,
            32'(TO + 1));
        stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("tmo_init", 32'(initd), 32'd0);
        wait_sv(7, "w_reinit");
        chk("re_id", xw(12), mk(6'h00, 1'b1, 1'b0, 8'h00));
        chk("re_bw", xw(13), mk(6'h2C, 1'b0, 1'b0, 8'h0A));
        chk("re_df", xw(14), mk(6'h31, 1'b0, 1'b0, 8'h08));
        chk("re_pc", xw(15), mk(6'h2D, 1'b0, 1'b0, 8'h08));
        chk("re_rd", xw(16), mk(6'h32, 1'b1, 1'b1, 8'd6));
        chk("re_init", 32'(initd), 32'd1);
        chk("re_x", 32'(ox), 32'h1234);

        repeat (20) @(negedge clk);
        devid = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_x", 32'(ox), 32'd0);
        chk("rst2_init", 32'(initd), 32'd0);
        log_q.delete();
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("bad_iderr", 32'(iderr), 32'd1);
        chk("bad_nocfg", 32'(log_q.size()), 32'd1);
        chk("bad_init", 32'(initd), 32'd0);
        devid = 8'hE5;
        repeat (200) @(negedge clk);
        chk("retry_gap", gap(0, 1), 32'(RT + 5));
        chk("retry_id", xw(1), mk(6'h00, 1'b1, 1'b0, 8'h00));
        chk("retry_bw", xw(2), mk(6'h2C, 1'b0, 1'b0, 8'h0A));
        chk("retry_iderr", 32'(iderr), 32'd0);
        chk("retry_init", 32'(initd), 32'd1);
        chk("start_ready", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
